// File: rtl/rf_pkg.sv
// Shared constants, arbiter state encoding and one-hot decode for the
// tri-stated flip-flop register file and its write arbiter.
package rf_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  // r0 is hard-wired zero, so write decodes can drop it via skip_r0
  function automatic logic [NREG-1:0] onehot_decode(input logic [AW-1:0] a,
                                                    input logic          skip_r0);
    logic [NREG-1:0] oh;
    oh = '0;
    if (!(skip_r0 && (a == '0))) oh[a] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Two-requester write handshake into the register-file arbiter:
// requesters hold req/addr/data until they see their one-cycle grant pulse.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          gnt0;
  logic          gnt1;

  modport master (
    output req0, req1, addr0, addr1, data0, data1,
    input  gnt0, gnt1
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1,
    output gnt0, gnt1
  );

endinterface

// File: rtl/rf_onehot_dec.sv
// Address to one-hot decoder, purely combinational (zero latency, no flow control).
// With r0_suppress set, address 0 decodes to all-zero.
module rf_onehot_dec
  import rf_pkg::*;
(
  input  logic [AW-1:0]   addr,
  input  logic            r0_suppress,
  output logic [NREG-1:0] onehot
);

  assign onehot = onehot_decode(addr, r0_suppress);

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter + read-enable decode for the register file;
// grant/wr_en registered one edge after req, a granted port is masked for one cycle.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                clr_n,
  rf_write_arbiter_if.slave   wr,
  output logic [NREG-1:0]     wr_en,
  output logic [DW-1:0]       wr_data,
  input  logic [AW-1:0]       rd_addr_a,
  input  logic [AW-1:0]       rd_addr_b,
  output logic [NREG-1:0]     rd_en_a,
  output logic [NREG-1:0]     rd_en_b,
  output logic                rf_clr
);

  state_t          state;
  logic            last;
  logic            clr_hold;
  logic            elig0;
  logic            elig1;
  logic            pick0;
  logic            pick1;
  logic [AW-1:0]   wsel_addr;
  logic [NREG-1:0] wsel_onehot;

  // The port granted on the last edge has not yet seen its gnt, so its req is stale
  assign elig0 = wr.req0 && (state != G0);
  assign elig1 = wr.req1 && (state != G1);
  assign pick0 = elig0 && (!elig1 || last);
  assign pick1 = elig1 && (!elig0 || !last);

  assign wsel_addr = pick1 ? wr.addr1 : wr.addr0;

  rf_onehot_dec u_wr_dec (
    .addr        (wsel_addr),
    .r0_suppress (1'b1),
    .onehot      (wsel_onehot)
  );

  rf_onehot_dec u_rd_dec_a (
    .addr        (rd_addr_a),
    .r0_suppress (1'b0),
    .onehot      (rd_en_a)
  );

  rf_onehot_dec u_rd_dec_b (
    .addr        (rd_addr_b),
    .r0_suppress (1'b0),
    .onehot      (rd_en_b)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= IDLE;
      wr.gnt0  <= 1'b0;
      wr.gnt1  <= 1'b0;
      wr_en    <= '0;
      wr_data  <= '0;
      last     <= 1'b1;
      rf_clr   <= 1'b1;
      clr_hold <= 1'b1;
    end else begin
      // clear stays up for one cycle past release
      rf_clr   <= clr_hold;
      clr_hold <= 1'b0;
      if (pick0) begin
        state   <= G0;
        wr.gnt0 <= 1'b1;
        wr.gnt1 <= 1'b0;
        last    <= 1'b0;
        wr_data <= wr.data0;
        wr_en   <= wsel_onehot;
      end else if (pick1) begin
        state   <= G1;
        wr.gnt0 <= 1'b0;
        wr.gnt1 <= 1'b1;
        last    <= 1'b1;
        wr_data <= wr.data1;
        wr_en   <= wsel_onehot;
      end else begin
        state   <= IDLE;
        wr.gnt0 <= 1'b0;
        wr.gnt1 <= 1'b0;
        wr_en   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a negedge-capture register-file model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic            clk;
  logic            clr_n;
  logic [NREG-1:0] wr_en;
  logic [DW-1:0]   wr_data;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic [NREG-1:0] rd_en_a;
  logic [NREG-1:0] rd_en_b;
  logic            rf_clr;

  int n_total = 0;
  int n_pass  = 0;

  rf_write_arbiter_if wif ();

  rf_write_arbiter dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .wr        (wif),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_en_a   (rd_en_a),
    .rd_en_b   (rd_en_b),
    .rf_clr    (rf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: cells capture on the negedge, clear has priority
  logic [DW-1:0] rf_model [NREG];
  always @(negedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rf_clr === 1'b1)      rf_model[i] <= '0;
      else if (wr_en[i] === 1'b1) rf_model[i] <= wr_data;
    end
  end

  function automatic logic [DW-1:0] read_a();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++)
      if (rd_en_a[i]) r = r | rf_model[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NREG-1:0] exp_wen;
    logic [NREG-1:0] exp_ren;
    logic [DW-1:0] exp_rd;
  } wvec_t;

  typedef struct {
    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic [NREG-1:0] ea;
    logic [NREG-1:0] eb;
  } rvec_t;

  wvec_t           wv [5];
  rvec_t           rv [4];
  logic [NREG-1:0] stream_wen [4];

  initial begin
    wv[0] = '{1'b0, 5'd5,  32'hDEAD_BEEF, 32'h0000_0020, 32'h0000_0020, 32'hDEAD_BEEF};
    wv[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
    wv[2] = '{1'b1, 5'd31, 32'hA5A5_0F0F, 32'h8000_0000, 32'h8000_0000, 32'hA5A5_0F0F};
    wv[3] = '{1'b0, 5'd1,  32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 32'h0000_0001};
    wv[4] = '{1'b1, 5'd16, 32'hCAFE_F00D, 32'h0001_0000, 32'h0001_0000, 32'hCAFE_F00D};
    rv[0] = '{5'd0,  5'd0, 32'h0000_0001, 32'h0000_0001};
    rv[1] = '{5'd31, 5'd5, 32'h8000_0000, 32'h0000_0020};
    rv[2] = '{5'd7,  5'd7, 32'h0000_0080, 32'h0000_0080};
    rv[3] = '{5'd16, 5'd1, 32'h0001_0000, 32'h0000_0002};
    stream_wen[0] = 32'h0000_0400;
    stream_wen[1] = 32'h0000_0800;
    stream_wen[2] = 32'h0000_1000;
    stream_wen[3] = 32'h0000_2000;

    clr_n     = 1'b0;
    wif.req0  = 1'b0;
    wif.req1  = 1'b0;
    wif.addr0 = '0;
    wif.addr1 = '0;
    wif.data0 = '0;
    wif.data1 = '0;
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd9;

    // Reset: three cycles low, outputs quiet, clear asserted, read decode live
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_gnt0", wif.gnt0, 1'b0);
      chk("rst_gnt1", wif.gnt1, 1'b0);
      chk("rst_wr_en", wr_en, 32'h0);
      chk("rst_wr_data", wr_data, 32'h0);
      chk("rst_rf_clr", rf_clr, 1'b1);
    end
    chk("rst_rd_en_a", rd_en_a, 32'h0000_0008);
    chk("rst_rd_en_b", rd_en_b, 32'h0000_0200);
    clr_n = 1'b1;
    step();
    chk("rf_clr_after_release", rf_clr, 1'b1);
    step();
    chk("rf_clr_drops", rf_clr, 1'b0);

    // Read decode table
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = rv[i].a;
      rd_addr_b = rv[i].b;
      #1;
      chk("rd_en_a", rd_en_a, rv[i].ea);
      chk("rd_en_b", rd_en_b, rv[i].eb);
    end

    // Single-request writes, then read back through port A
    for (int i = 0; i < 5; i++) begin
      wif.req0  = !wv[i].port;
      wif.req1  = wv[i].port;
      wif.addr0 = wv[i].addr;
      wif.addr1 = wv[i].addr;
      wif.data0 = wv[i].data;
      wif.data1 = wv[i].data;
      step();
      chk("wr_gnt0", wif.gnt0, !wv[i].port);
      chk("wr_gnt1", wif.gnt1, wv[i].port);
      chk("wr_en", wr_en, wv[i].exp_wen);
      chk("wr_data", wr_data, wv[i].data);
      wif.req0  = 1'b0;
      wif.req1  = 1'b0;
      rd_addr_a = wv[i].addr;
      step();
      chk("wr_gnt_drop", {wif.gnt0, wif.gnt1}, 2'b00);
      chk("wr_en_drop", wr_en, 32'h0);
      chk("wr_data_hold", wr_data, wv[i].data);
      chk("wr_rd_en_a", rd_en_a, wv[i].exp_ren);
      chk("wr_readback", read_a(), wv[i].exp_rd);
    end

    // Contention straight after reset: port 0 first, then strict alternation
    clr_n = 1'b0;
    step();
    clr_n     = 1'b1;
    wif.req0  = 1'b1;
    wif.req1  = 1'b1;
    wif.addr0 = 5'd3;
    wif.addr1 = 5'd7;
    wif.data0 = 32'h0000_0A0A;
    wif.data1 = 32'h0000_0B0B;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("cont_gnt0", wif.gnt0, (c % 2) == 0);
      chk("cont_gnt1", wif.gnt1, (c % 2) == 1);
      chk("cont_wr_en", wr_en, ((c % 2) == 0) ? 32'h0000_0008 : 32'h0000_0080);
      chk("cont_wr_data", wr_data, ((c % 2) == 0) ? 32'h0000_0A0A : 32'h0000_0B0B);
    end
    wif.req0 = 1'b0;
    wif.req1 = 1'b0;
    step();
    chk("cont_idle", {wif.gnt0, wif.gnt1}, 2'b00);

    // Port 1 streams four items: grant every second cycle
    begin
      int item;
      item      = 0;
      wif.req1  = 1'b1;
      wif.addr1 = 5'd10;
      wif.data1 = 32'h1000_0000;
      for (int c = 0; c < 8; c++) begin
        step();
        chk("stream_gnt1", wif.gnt1, (c % 2) == 0);
        chk("stream_wr_en", wr_en, ((c % 2) == 0) ? stream_wen[c / 2] : 32'h0);
        if (wif.gnt1) begin
          item++;
          if (item < 4) begin
            wif.addr1 = AW'(10 + item);
            wif.data1 = 32'h1000_0000 + DW'(item);
          end else begin
            wif.req1 = 1'b0;
          end
        end
      end
      chk("stream_items", item, 4);
    end

    // Reset sampled on the edge after req0 rises: reset wins, req stays pending
    wif.req0  = 1'b1;
    wif.addr0 = 5'd9;
    wif.data0 = 32'h1234_5678;
    clr_n     = 1'b0;
    step();
    chk("mid_gnt0", wif.gnt0, 1'b0);
    chk("mid_wr_en", wr_en, 32'h0);
    chk("mid_rf_clr", rf_clr, 1'b1);
    clr_n = 1'b1;
    step();
    chk("mid_regrant_gnt0", wif.gnt0, 1'b1);
    chk("mid_regrant_wr_en", wr_en, 32'h0000_0200);
    chk("mid_regrant_data", wr_data, 32'h1234_5678);
    chk("mid_regrant_rf_clr", rf_clr, 1'b1);
    wif.req0 = 1'b0;
    step();
    chk("mid_end_gnt0", wif.gnt0, 1'b0);
    chk("mid_end_rf_clr", rf_clr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequencing and sharing controller for the negedge-capture register file built from enabled, tri-stated flip-flop cells. Two requesters share the single write port: processor writeback (port 0) and the sensor/IO interface (port 1). The block arbitrates them round-robin with a req/gnt handshake and drives the one-hot per-register write enables and the write data. It also decodes both read-port addresses into one-hot tri-state output enables and generates the register file's active-high clear.

## Interface
- NREG, 32, number of registers; power of two
- AW, 5, address width, log2(NREG)
- DW, 32, data width
- clk  in  1  system clock; all state updates on posedge
- clr_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  write request; held with addr/data until granted
- addr0 / addr1  in  AW  target register
- data0 / data1  in  DW  write data
- gnt0 / gnt1  out  1  registered one-cycle grant pulse
- wr_en  out  NREG  one-hot per-register write enable (to cell in_en)
- wr_data  out  DW  write data to all cells
- rd_addr_a / rd_addr_b  in  AW  read-port addresses
- rd_en_a / rd_en_b  out  NREG  one-hot tri-state enables (to cell out_en)
- rf_clr  out  1  active-high register-file clear

## Operation
- **Reset.** clr_n sampled low at a posedge sets:
  - state = IDLE, gnt0 = gnt1 = 0, wr_en = 0, wr_data = 0
  - round-robin pointer last = 1, so port 0 wins first
  - rf_clr = 1
- **rf_clr.** Registered. It is 1 on every cycle that follows a reset sample, plus exactly one further cycle after clr_n is sampled high. After that it is 0.
- **States.** The FSM has three states: IDLE, G0, G1. The state encodes which port was granted on the last edge.
- **Eligibility.**
  - In G0, req0 is masked for one cycle because it is stale: the requester has not yet seen gnt0. G1 masks req1 the same way.
  - IDLE masks nothing.
- **Arbitration**, at each posedge, on eligible requests:
  - Exactly one eligible request: grant it.
  - Both eligible: grant the port that is not `last`.
  - None eligible: go to IDLE.
- **Grant edge.** The edge that grants port k does all of the following:
  - state → Gk, gnt_k = 1, last = k
  - wr_data ← data_k
  - wr_en ← one-hot(addr_k)
- **Register 0.** If addr_k = 0, wr_en stays all-zero. The handshake still completes (gnt_k pulses), so the write is silently dropped and r0 stays 0.
- **Non-grant edges.** gnt0, gnt1 and wr_en go to 0. wr_data holds its last value.
- **Read enables.** Combinational: rd_en_a = one-hot(rd_addr_a), rd_en_b = one-hot(rd_addr_b).
  - Exactly one bit is set, including for address 0.
  - Both ports may select the same register.
  - rd_en_a and rd_en_b are not affected by reset.
- **Requester rule.** Keep req, addr and data stable until gnt is sampled 1. Then drop req or present new data in the next cycle.
  - Withdrawing a request before it is granted is legal; nothing is written.

## Timing
- **Write latency.** req sampled at edge n → gnt and wr_en high during cycle n..n+1 → register cells capture at the intervening negedge → readable from the cycle after edge n+1.
- **Throughput.**
  - One write per cycle when both ports alternate.
  - One write per 2 cycles for a single continuous requester, because of the mask cycle.
- **Fairness.** Under continuous contention, grants strictly alternate. No port waits more than 2 cycles.
- **Simultaneous events.**
  - If reset is sampled on the same edge as a request, reset wins: no grant, and the request stays pending.
  - Reset mid-grant: gnt and wr_en drop at the reset edge. A write already captured at the preceding negedge stands; rf_clr then clears it.
- **wr_en invariant.** wr_en is never more than one-hot. gnt0 and gnt1 are never high together.

## Structure
- **Shared package** (rf_pkg):
  - NREG, AW, DW constants
  - state enum {IDLE, G0, G1}
  - onehot_decode function, reused by the register-file top
- **Sub-module** rf_onehot_dec (AW → NREG, combinational).
  - Three instances: write decode before the wr_en register, and read ports A and B.
  - The write instance has an r0-suppress enable tied on; the read instances have it off.
- The arbiter FSM and output registers stay in the top module.

## Test plan
- **Reset.** Hold clr_n = 0 for 3 cycles, then release. Check during reset: gnt = 0, wr_en = 0, wr_data = 0, rf_clr = 1 through the cycle after release, then 0.
- **Single write.** req0 with addr0 = 5, data0 = 0xDEADBEEF. Expect gnt0 one cycle later, wr_en = 0x00000020, wr_data = 0xDEADBEEF. Register 5 then reads back through rd_en_a = 0x20.
- **Contention.** req0 and req1 held continuously (addr 3, addr 7). Grants alternate gnt0, gnt1, gnt0, … starting with port 0 after reset. wr_en alternates 0x08 / 0x80.
- **Single-port stream.** Port 1 streams 4 writes, presenting a new item on the cycle after each gnt1. Expect gnt1 every second cycle, with an idle mask cycle in between.
- **Register 0 write.** req1, addr1 = 0, data1 = 0xFFFFFFFF. Expect gnt1 pulses, wr_en = 0, and r0 still reads 0.
- **Reset mid-grant.** clr_n = 0 sampled on the edge after req0 is asserted. Expect no gnt0, and rf_clr = 1. After release, the still-held req0 is granted with latency 1.
